keyreg_multi: RTL and testbench

Parametrised key-entry shift buffer for the alarm-clock keypad path. It sits between the keypad FSM and the alarm/time registers. It stores the last NUM_DIGITS keys pressed, and adds what the fixed 4-digit buffer lacks:
- backspace and clear
- an entered-digit counter with full and done flags
- optional rejection of non-decimal keys

---
 rtl/keyreg_pkg.sv | 19 +
 rtl/keyreg_op_decode.sv | 45 ++++
 rtl/keyreg_multi.sv | 128 ++++++++++++
 tb/tb_keyreg_multi.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keyreg_pkg.sv
// Shared types and helpers for the keypad key-entry buffer.
// Optional key validation is enabled by KEYREG_DIGIT_CHECK_EN.
package keyreg_pkg;

    localparam int unsigned KEY_DIGIT_MAX = 9;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLEAR,
        OP_OVERWRITE,
        OP_SHIFT,
        OP_BKSP
    } op_e;

    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/keyreg_op_decode.sv
// Priority decode of clear/shift/backspace into one buffer operation.
// Key range check is compiled in only with KEYREG_DIGIT_CHECK_EN.
module keyreg_op_decode
    import keyreg_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic               clear,
    input  logic               shift,
    input  logic               backspace,
    input  logic [DIGIT_W-1:0] key,
    output op_e                op,
    output logic               reject_next
);

    logic key_ok;

`ifdef KEYREG_DIGIT_CHECK_EN
    assign key_ok = (key <= DIGIT_W'(KEY_DIGIT_MAX));
`else
    logic unused_key;
    assign unused_key = ^key;
    assign key_ok     = 1'b1;
`endif

    always_comb begin
        op          = OP_NONE;
        reject_next = 1'b0;
        if (clear) begin
            op = OP_CLEAR;
        end else if (shift) begin
            // a refused key drops the whole operation, backspace included
            if (!key_ok) begin
                reject_next = 1'b1;
            end else if (backspace) begin
                op = OP_OVERWRITE;
            end else begin
                op = OP_SHIFT;
            end
        end else if (backspace) begin
            op = OP_BKSP;
        end
    end

endmodule

// File: rtl/keyreg_multi.sv
// Key-entry shift buffer with backspace, clear, digit counter and flags.
// Define KEYREG_DIGIT_CHECK_EN to refuse non-decimal keys and drive reject.
module keyreg_multi
    import keyreg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  shift,
    input  logic [DIGIT_W-1:0]                    key,
    input  logic                                  backspace,
    input  logic                                  clear,
    output logic [NUM_DIGITS*DIGIT_W-1:0]         key_buffer,
    output logic [count_width(NUM_DIGITS)-1:0]    digit_count,
    output logic                                  full,
    output logic                                  done,
    output logic                                  reject
);

    localparam int CNT_W = count_width(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);

    op_e              op;
    logic             reject_next;

    logic [DIGIT_W-1:0] slot_q [NUM_DIGITS];
    logic [DIGIT_W-1:0] slot_d [NUM_DIGITS];
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;

    keyreg_op_decode #(
        .DIGIT_W     (DIGIT_W)
    ) u_decode (
        .clear       (clear),
        .shift       (shift),
        .backspace   (backspace),
        .key         (key),
        .op          (op),
        .reject_next (reject_next)
    );

    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        unique case (op)
            OP_CLEAR: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    slot_d[i] = '0;
                end
                count_d = '0;
            end
            OP_OVERWRITE: begin
                slot_d[0] = key;
                if (count_q == '0) begin
                    count_d = CNT_W'(1);
                end
            end
            OP_SHIFT: begin
                for (int i = 1; i < NUM_DIGITS; i++) begin
                    slot_d[i] = slot_q[i-1];
                end
                slot_d[0] = key;
                if (count_q != CNT_FULL) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            OP_BKSP: begin
                for (int i = 0; i < NUM_DIGITS - 1; i++) begin
                    slot_d[i] = slot_q[i+1];
                end
                slot_d[NUM_DIGITS-1] = '0;
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // only a rising transition into full fires done
    assign done_d = (count_d == CNT_FULL) && (count_q != CNT_FULL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_q[i] <= '0;
            end
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

`ifdef KEYREG_DIGIT_CHECK_EN
    logic reject_q, reject_d;

    assign reject_d = reject_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reject_q <= 1'b0;
        end else begin
            reject_q <= reject_d;
        end
    end

    assign reject = reject_q;
`else
    logic unused_reject;
    assign unused_reject = reject_next;
    assign reject        = 1'b0;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pack
        assign key_buffer[g*DIGIT_W +: DIGIT_W] = slot_q[g];
    end

    assign digit_count = count_q;
    assign full        = (count_q == CNT_FULL);
    assign done        = done_q;

endmodule

// File: tb/tb_keyreg_multi.sv
// Bench for keyreg_multi: 4-digit and 6-digit instances on shared stimulus,
// directed scenarios plus random traffic against a digit-list model.
module tb_keyreg_multi;

    logic        clock;
    logic        reset;
    logic        shift;
    logic [3:0]  key;
    logic        backspace;
    logic        clear;

    logic [15:0] kb4;
    logic [2:0]  cnt4;
    logic        full4, done4, rej4;
    logic [23:0] kb6;
    logic [2:0]  cnt6;
    logic        full6, done6, rej6;

    int checks;
    int failures;

    int md [2][8];
    int mc [2];
    bit mdone [2];
    bit mrej [2];

    keyreg_multi #(.NUM_DIGITS(4), .DIGIT_W(4)) u_dut4 (
        .clock       (clock),
        .reset       (reset),
        .shift       (shift),
        .key         (key),
        .backspace   (backspace),
        .clear       (clear),
        .key_buffer  (kb4),
        .digit_count (cnt4),
        .full        (full4),
        .done        (done4),
        .reject      (rej4)
    );

    keyreg_multi #(.NUM_DIGITS(6), .DIGIT_W(4)) u_dut6 (
        .clock       (clock),
        .reset       (reset),
        .shift       (shift),
        .key         (key),
        .backspace   (backspace),
        .clear       (clear),
        .key_buffer  (kb6),
        .digit_count (cnt6),
        .full        (full6),
        .done        (done6),
        .reject      (rej6)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit key_ok(input int kv);
`ifdef KEYREG_DIGIT_CHECK_EN
        return kv <= 9;
`else
        return 1'b1;
`endif
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) md[k][i] = 0;
            mc[k]    = 0;
            mdone[k] = 0;
            mrej[k]  = 0;
        end
    endtask

    // digit list, index 0 = newest entry
    task automatic m_step(input int k, input int n, input bit c,
                          input bit s, input bit b, input int kv);
        int prev;
        prev     = mc[k];
        mrej[k]  = 0;
        if (c) begin
            for (int i = 0; i < 8; i++) md[k][i] = 0;
            mc[k] = 0;
        end else if (s && !key_ok(kv)) begin
            mrej[k] = 1;
        end else if (s && b) begin
            md[k][0] = kv;
            if (mc[k] == 0) mc[k] = 1;
        end else if (s) begin
            for (int i = n - 1; i > 0; i--) md[k][i] = md[k][i-1];
            md[k][0] = kv;
            mc[k] = (mc[k] + 1 > n) ? n : mc[k] + 1;
        end else if (b) begin
            for (int i = 0; i < n - 1; i++) md[k][i] = md[k][i+1];
            md[k][n-1] = 0;
            mc[k] = (mc[k] > 0) ? mc[k] - 1 : 0;
        end
        mdone[k] = (prev < n) && (mc[k] == n);
    endtask

    function automatic logic [63:0] mbuf(input int k, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = r | (64'(md[k][i]) << (4 * i));
        return r;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_buf4"}, 64'(kb4), mbuf(0, 4));
        chk({tag, "_cnt4"}, 64'(cnt4), 64'(mc[0]));
        chk({tag, "_full4"}, 64'(full4), 64'(mc[0] == 4));
        chk({tag, "_done4"}, 64'(done4), 64'(mdone[0]));
        chk({tag, "_rej4"}, 64'(rej4), 64'(mrej[0]));
        chk({tag, "_buf6"}, 64'(kb6), mbuf(1, 6));
        chk({tag, "_cnt6"}, 64'(cnt6), 64'(mc[1]));
        chk({tag, "_full6"}, 64'(full6), 64'(mc[1] == 6));
        chk({tag, "_done6"}, 64'(done6), 64'(mdone[1]));
        chk({tag, "_rej6"}, 64'(rej6), 64'(mrej[1]));
    endtask

    task automatic cyc(input string tag, input bit c, input bit s,
                       input bit b, input int kv);
        clear     = c;
        shift     = s;
        backspace = b;
        key       = 4'(kv);
        m_step(0, 4, c, s, b, kv);
        m_step(1, 6, c, s, b, kv);
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        clear = 0; shift = 0; backspace = 0; key = '0;
    endtask

    // reset lands between edges while a shift is pending
    task automatic async_reset(input string tag);
        shift = 1;
        key   = 4'd5;
        #2;
        reset = 1;
        #1;
        m_reset();
        check_all({tag, "_imm"});
        @(posedge clock);
        #1;
        check_all({tag, "_hold"});
        idle_inputs();
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        int c_r, s_r, b_r, k_r;
        checks   = 0;
        failures = 0;
        reset    = 1;
        idle_inputs();
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("rst");
        reset = 0;

        cyc("t1a", 0, 1, 0, 1);
        chk("t1a_cnt", 64'(cnt4), 64'd1);
        cyc("t1b", 0, 1, 0, 2);
        cyc("t1c", 0, 1, 0, 3);
        cyc("t1d", 0, 1, 0, 4);
        chk("t1_buf", 64'(kb4), 64'h1234);
        chk("t1_done", 64'(done4), 64'd1);
        chk("t1_full", 64'(full4), 64'd1);

        cyc("t2a", 0, 1, 0, 5);
        chk("t2_buf", 64'(kb4), 64'h2345);
        chk("t2_done", 64'(done4), 64'd0);
        cyc("t2b", 0, 0, 1, 0);
        chk("t2_bk", 64'(kb4), 64'h0234);
        chk("t2_cnt", 64'(cnt4), 64'd3);
        chk("t2_full", 64'(full4), 64'd0);

        cyc("t3a", 0, 1, 1, 7);
        chk("t3_ovw", 64'(kb4), 64'h0237);
        chk("t3_cnt", 64'(cnt4), 64'd3);
        cyc("t3b", 1, 1, 0, 3);
        chk("t3_clr", 64'(kb4), 64'h0);
        chk("t3_cnt0", 64'(cnt4), 64'd0);

        cyc("t4a", 0, 1, 0, 1);
        cyc("t4b", 0, 1, 0, 2);
        cyc("t4c", 0, 1, 0, 11);
`ifdef KEYREG_DIGIT_CHECK_EN
        chk("t4_buf", 64'(kb4), 64'h0012);
        chk("t4_cnt", 64'(cnt4), 64'd2);
        chk("t4_rej", 64'(rej4), 64'd1);
        cyc("t4d", 0, 1, 1, 12);
        chk("t4_ovw_rej", 64'(kb4), 64'h0012);
`else
        chk("t4_buf", 64'(kb4), 64'h012B);
        chk("t4_cnt", 64'(cnt4), 64'd3);
        chk("t4_rej", 64'(rej4), 64'd0);
`endif
        cyc("t4e", 0, 0, 0, 0);
        chk("t4_rej_off", 64'(rej4), 64'd0);

        cyc("t5a", 1, 0, 0, 0);
        cyc("t5b", 0, 1, 0, 8);
        for (int i = 0; i < 3; i++) begin
            cyc("t5bk", 0, 0, 1, 0);
            chk("t5_cnt", 64'(cnt4), 64'd0);
            chk("t5_buf", 64'(kb4), 64'h0);
        end
        cyc("t5c", 0, 1, 0, 3);
        cyc("t5d", 0, 1, 0, 4);
        async_reset("t5r");
        chk("t5_rbuf", 64'(kb4), 64'h0);

        cyc("t6c", 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc("t6s", 0, 1, 0, i);
            chk("t6_done", 64'(done6), 64'(i == 6));
        end
        chk("t6_buf", 64'(kb6), 64'h123456);
        chk("t6_cnt", 64'(cnt6), 64'd6);
        cyc("t6x", 0, 1, 0, 7);
        chk("t6_redone", 64'(done6), 64'd0);

        for (int n = 0; n < 600; n++) begin
            c_r = ($urandom_range(0, 15) == 0) ? 1 : 0;
            s_r = $urandom_range(0, 1);
            b_r = ($urandom_range(0, 3) == 0) ? 1 : 0;
            k_r = $urandom_range(0, 15);
            if ($urandom_range(0, 59) == 0) begin
                async_reset("rnd_rst");
            end else begin
                cyc("rnd", c_r[0], s_r[0], b_r[0], k_r);
            end
        end

        idle_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
